mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and data-memory port. It sits between the datapath (IM_addr/IM_readData and DM_addr/DM_writeData/DM_readData, DM_readEnable/DM_writeEnable) and a unified memory with a request/acknowledge handshake. It produces per-port stall signals so the pipeline freezes until its access completes. Data accesses have priority, with a bounded-streak rule so fetch cannot starve.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and unified-memory handshake signals.
// slave: the arbiter's view; master: the pipeline + memory environment.
interface mem_port_arbiter_if #(
    parameter int N = 64
);
    logic          if_req;
    logic [N-1:0]  if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          if_stall;

    logic          dm_read;
    logic          dm_write;
    logic [N-1:0]  dm_addr;
    logic [N-1:0]  dm_wdata;
    logic [N-1:0]  dm_rdata;
    logic          dm_ready;
    logic          dm_stall;

    logic          mem_req;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;
    logic          mem_ack;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one variable-latency memory.
// Data wins, except a waiting fetch is forced in after MAX_DSTREAK data grants.
module mem_port_arbiter #(
    parameter int N           = 64,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t       state;
    logic [3:0]   streak;
    logic         dm_pend;
    logic         take_d;
    logic [N-1:0] gnt_addr;

    assign dm_pend  = bus.dm_read | bus.dm_write;
    assign take_d   = dm_pend & (~bus.if_req | (streak != STREAK_MAX));
    assign gnt_addr = take_d ? bus.dm_addr : bus.if_addr;

    assign bus.if_stall = bus.if_req & ~bus.if_ready;
    assign bus.dm_stall = dm_pend & ~bus.dm_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            streak        <= 4'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take_d) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= gnt_addr;
                        bus.mem_we    <= bus.dm_write;
                        bus.mem_wdata <= bus.dm_wdata;
                        state         <= BUSY_D;
                        // Streak only counts grants that made a fetch wait.
                        if (!bus.if_req)
                            streak <= 4'd0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 4'd1;
                    end else if (bus.if_req) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= gnt_addr;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= '0;
                        state         <= BUSY_I;
                        streak        <= 4'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= RESP;
                        if (state == BUSY_D) begin
                            bus.dm_rdata <= bus.mem_rdata;
                            bus.dm_ready <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata[31:0];
                            bus.if_ready <= 1'b1;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboard, and hand sequences.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N(64)) bus ();

    mem_port_arbiter #(.N(64), .MAX_DSTREAK(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_d;
        logic [63:0] addr;
        bit          we;
        logic [63:0] wdata;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit          rd, wr, fe;
        logic [63:0] addr, wdata;
        int          dly;
        bit          exp_we;
        logic [63:0] exp_wdata;
        int          exp_lat;
    } vec_t;
    vec_t vt[7];

    int   ack_delay = 0;
    int   cnt = 0;
    logic model_ack = 1'b0;
    logic spur_ack  = 1'b0;
    assign bus.mem_ack = model_ack | spur_ack;

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit d, input logic [63:0] a, input bit we, input logic [63:0] wd);
        sb_t e;
        e.is_d = d; e.addr = a; e.we = we; e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic run_until_ready(output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.if_ready || bus.dm_ready) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready in 60 cycles, expected a ready pulse");
        end
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    // Memory model: acks after ack_delay extra cycles of mem_req, data is a hash of address.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            cnt           = 0;
            model_ack     = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
        end else if (model_ack) begin
            model_ack = 1'b0;
            cnt       = 0;
        end else if (bus.mem_req) begin
            if (cnt >= ack_delay) begin
                model_ack     = 1'b1;
                bus.mem_rdata = mem_val(bus.mem_addr);
            end else begin
                cnt++;
            end
        end
    end

    // Scoreboard: request fields at ack, port and read data at ready.
    always @(negedge clk) begin
        sb_t         e;
        logic [63:0] v;
        if (reset === 1'b1) begin
            if (bus.mem_req && bus.mem_ack) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_grant: got mem_req to %0h, expected no request", bus.mem_addr);
                end else begin
                    chk("mem_addr",  bus.mem_addr,        sb[0].addr);
                    chk("mem_we",    64'(bus.mem_we),     64'(sb[0].we));
                    chk("mem_wdata", bus.mem_wdata,       sb[0].wdata);
                end
            end
            if (bus.if_ready || bus.dm_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ready: got if_ready=%0b dm_ready=%0b, expected none",
                             bus.if_ready, bus.dm_ready);
                end else begin
                    e = sb.pop_front();
                    v = mem_val(e.addr);
                    chk("ready_port", {bus.if_ready, bus.dm_ready}, e.is_d ? 64'd1 : 64'd2);
                    if (e.is_d) chk("dm_rdata", bus.dm_rdata, v);
                    else        chk("if_rdata", 64'(bus.if_rdata), {32'b0, v[31:0]});
                end
            end
        end
    end

    initial begin
        int lat;
        int stall_cnt, nd, ni;
        bit seen_i;

        vt[0] = '{rd:0, wr:0, fe:1, addr:64'h40,  wdata:64'h0,    dly:2, exp_we:0, exp_wdata:64'h0,    exp_lat:4};
        vt[1] = '{rd:0, wr:1, fe:0, addr:64'h100, wdata:64'hDEAD, dly:0, exp_we:1, exp_wdata:64'hDEAD, exp_lat:2};
        vt[2] = '{rd:1, wr:0, fe:0, addr:64'h180, wdata:64'h5555, dly:1, exp_we:0, exp_wdata:64'h5555, exp_lat:3};
        vt[3] = '{rd:0, wr:0, fe:1, addr:64'h44,  wdata:64'h7777, dly:0, exp_we:0, exp_wdata:64'h0,    exp_lat:2};
        vt[4] = '{rd:1, wr:1, fe:0, addr:64'h1C0, wdata:64'h1234, dly:3, exp_we:1, exp_wdata:64'h1234, exp_lat:5};
        vt[5] = '{rd:1, wr:0, fe:0, addr:64'h0,   wdata:64'h0,    dly:0, exp_we:0, exp_wdata:64'h0,    exp_lat:2};
        vt[6] = '{rd:0, wr:0, fe:1, addr:64'hFFFF_FFFF_FFFF_FFFC, wdata:64'h0, dly:1, exp_we:0,
                  exp_wdata:64'h0, exp_lat:3};

        reset = 1'b0;
        idle_inputs();

        // Held in reset with random inputs and spurious acks: every output stays 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.if_req   = 1'($urandom);
            bus.if_addr  = {$urandom, $urandom};
            bus.dm_read  = 1'($urandom);
            bus.dm_write = 1'($urandom);
            bus.dm_addr  = {$urandom, $urandom};
            bus.dm_wdata = {$urandom, $urandom};
            spur_ack     = 1'($urandom);
            #1;
            chk("rst_mem_req",   64'(bus.mem_req),  64'd0);
            chk("rst_mem_we",    64'(bus.mem_we),   64'd0);
            chk("rst_mem_addr",  bus.mem_addr,      64'd0);
            chk("rst_mem_wdata", bus.mem_wdata,     64'd0);
            chk("rst_if_ready",  64'(bus.if_ready), 64'd0);
            chk("rst_dm_ready",  64'(bus.dm_ready), 64'd0);
            chk("rst_if_rdata",  64'(bus.if_rdata), 64'd0);
            chk("rst_dm_rdata",  bus.dm_rdata,      64'd0);
            chk("rst_if_stall",  64'(bus.if_stall), 64'(bus.if_req));
        end
        @(negedge clk);
        idle_inputs();
        spur_ack = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        // Single transactions from the vector table.
        for (int i = 0; i < 7; i++) begin
            ack_delay    = vt[i].dly;
            bus.if_req   = vt[i].fe;
            bus.if_addr  = vt[i].fe ? vt[i].addr : 64'h0;
            bus.dm_read  = vt[i].rd;
            bus.dm_write = vt[i].wr;
            bus.dm_addr  = vt[i].addr;
            bus.dm_wdata = vt[i].wdata;
            push(!vt[i].fe, vt[i].addr, vt[i].exp_we, vt[i].exp_wdata);
            #1;
            chk("stall_at_req", 64'(vt[i].fe ? bus.if_stall : bus.dm_stall), 64'd1);
            run_until_ready(lat);
            chk("latency", 64'(lat), 64'(vt[i].exp_lat));
            chk("stall_at_ready", 64'({bus.if_stall, bus.dm_stall}), 64'd0);
            idle_inputs();
            @(negedge clk);
        end

        // Address changes after grant must not reach the memory.
        ack_delay   = 5;
        bus.dm_read = 1'b1;
        bus.dm_addr = 64'h8;
        push(1'b1, 64'h8, 1'b0, 64'h0);
        repeat (2) @(negedge clk);
        bus.dm_addr = 64'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_mem_addr_hold", bus.mem_addr, 64'h8);
        end
        run_until_ready(lat);
        idle_inputs();
        @(negedge clk);

        // Both ports hammering: D,D,D,D,I twice.
        ack_delay = 0;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) push(1'b1, 64'h300, 1'b0, 64'h0);
            push(1'b0, 64'h200, 1'b0, 64'h0);
        end
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h200;
        bus.dm_read = 1'b1;
        bus.dm_addr = 64'h300;
        #1;
        stall_cnt = bus.if_stall ? 1 : 0;
        nd = 0; ni = 0; seen_i = 1'b0;
        for (int c = 0; c < 100 && (nd < 8 || ni < 2); c++) begin
            @(negedge clk);
            if (!seen_i && bus.if_stall) stall_cnt++;
            if (bus.dm_ready) begin
                nd++;
                if (nd == 8) bus.dm_read = 1'b0;
            end
            if (bus.if_ready) begin
                ni++;
                seen_i = 1'b1;
                if (ni == 2) bus.if_req = 1'b0;
            end
        end
        chk("conflict_if_stall_cycles", 64'(stall_cnt), 64'd14);
        chk("conflict_data_grants",     64'(nd),        64'd8);
        chk("conflict_fetch_grants",    64'(ni),        64'd2);
        idle_inputs();
        @(negedge clk);
        chk("conflict_sb_drained", 64'(sb.size()), 64'd0);

        // Reset two cycles after grant abandons the access; request is re-granted.
        ack_delay   = 6;
        bus.dm_read = 1'b1;
        bus.dm_addr = 64'h20;
        push(1'b1, 64'h20, 1'b0, 64'h0);
        for (int c = 0; c < 10 && !bus.mem_req; c++) @(negedge clk);
        chk("midrst_granted", 64'(bus.mem_req), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_mem_req",  64'(bus.mem_req), 64'd0);
        chk("midrst_mem_addr", bus.mem_addr,     64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("midrst_no_ready", 64'({bus.if_ready, bus.dm_ready}), 64'd0);
        end
        reset = 1'b1;
        run_until_ready(lat);
        chk("midrst_regrant_latency", 64'(lat), 64'd8);
        idle_inputs();
        @(negedge clk);

        // Spurious ack in IDLE.
        ack_delay = 0;
        spur_ack  = 1'b1;
        @(negedge clk);
        spur_ack  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("spur_idle_quiet", 64'({bus.mem_req, bus.if_ready, bus.dm_ready}), 64'd0);
        end

        // Spurious ack in RESP, then confirm arbitration restarts normally.
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h80;
        push(1'b0, 64'h80, 1'b0, 64'h0);
        run_until_ready(lat);
        chk("spur_fetch_latency", 64'(lat), 64'd2);
        spur_ack    = 1'b1;
        bus.if_req  = 1'b0;
        @(negedge clk);
        spur_ack    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("spur_resp_quiet", 64'({bus.mem_req, bus.if_ready, bus.dm_ready}), 64'd0);
            @(negedge clk);
        end
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h84;
        push(1'b0, 64'h84, 1'b0, 64'h0);
        run_until_ready(lat);
        chk("post_spur_latency", 64'(lat), 64'd2);
        idle_inputs();
        @(negedge clk);
        chk("final_sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
